// File: rtl/bram_pkg.sv
// Shared state encoding and default widths for the BRAM port-B fill/arbitration scheduler.
package bram_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // prio_q high means c1 wins a tie (c0 was granted most recently)
  logic prio_q, prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (en) begin
      if (req[0] && (!req[1] || !prio_q)) begin
        gnt[0] = 1'b1;
      end else if (req[1]) begin
        gnt[1] = 1'b1;
      end
    end
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/bram_portb_sched.sv
// BRAM port-B scheduler: fills the BRAM with INIT_BASE+addr, then arbitrates two clients onto port B.
module bram_portb_sched
  import bram_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                RD_LAT    = DEF_RD_LAT,
  parameter logic [DATA_W-1:0] INIT_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit,
  output logic              init_done,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              portb_en,
  output logic              portb_we,
  output logic [ADDR_W-1:0] portb_addr,
  output logic [DATA_W-1:0] portb_din,
  input  logic [DATA_W-1:0] portb_dout
);

  localparam int FILL_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                pb_en_q, pb_en_d;
  logic                pb_we_q, pb_we_d;
  logic [ADDR_W-1:0]   pb_addr_q, pb_addr_d;
  logic [DATA_W-1:0]   pb_din_q, pb_din_d;
  logic [RD_LAT:0]     rd_vld_q, rd_vld_d;
  logic [RD_LAT:0]     rd_id_q, rd_id_d;
  logic                arb_en;
  logic [1:0]          gnt;

  assign arb_en = !rst && (state_q == ST_RUN) && !reinit;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({c1_req, c0_req}),
    .gnt (gnt)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    pb_en_d   = 1'b0;
    pb_we_d   = 1'b0;
    pb_addr_d = pb_addr_q;
    pb_din_d  = pb_din_q;
    rd_vld_d  = {rd_vld_q[RD_LAT-1:0], 1'b0};
    rd_id_d   = {rd_id_q[RD_LAT-1:0], 1'b0};
    unique case (state_q)
      ST_INIT: begin
        // The extra counter bit marks "last word already on port B", so RUN starts one cycle later
        if (!fill_q[ADDR_W]) begin
          pb_en_d   = 1'b1;
          pb_we_d   = 1'b1;
          pb_addr_d = fill_q[ADDR_W-1:0];
          pb_din_d  = INIT_BASE + DATA_W'(fill_q[ADDR_W-1:0]);
          fill_d    = fill_q + FILL_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reinit) begin
          state_d = ST_DRAIN;
          fill_d  = '0;
        end else if (gnt != 2'b00) begin
          pb_en_d     = 1'b1;
          pb_we_d     = gnt[1] ? c1_we    : c0_we;
          pb_addr_d   = gnt[1] ? c1_addr  : c0_addr;
          pb_din_d    = gnt[1] ? c1_wdata : c0_wdata;
          rd_vld_d[0] = !pb_we_d;
          rd_id_d[0]  = gnt[1];
        end
      end
      ST_DRAIN: begin
        if (rd_vld_q == '0) begin
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control state: reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      fill_q   <= '0;
      pb_en_q  <= 1'b0;
      pb_we_q  <= 1'b0;
      rd_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      pb_en_q  <= pb_en_d;
      pb_we_q  <= pb_we_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Data state: qualified by the control flops above, never reset
  always_ff @(posedge clk) begin
    pb_addr_q <= pb_addr_d;
    pb_din_q  <= pb_din_d;
    rd_id_q   <= rd_id_d;
  end

  // Every output is forced low combinationally while rst is high
  assign init_done  = !rst && (state_q == ST_RUN);
  assign c0_gnt     = gnt[0];
  assign c1_gnt     = gnt[1];
  assign c0_rvalid  = !rst && rd_vld_q[RD_LAT] && !rd_id_q[RD_LAT];
  assign c1_rvalid  = !rst && rd_vld_q[RD_LAT] &&  rd_id_q[RD_LAT];
  assign rdata      = (c0_rvalid || c1_rvalid) ? portb_dout : '0;
  assign portb_en   = !rst && pb_en_q;
  assign portb_we   = !rst && pb_we_q;
  assign portb_addr = rst ? '0 : pb_addr_q;
  assign portb_din  = rst ? '0 : pb_din_q;

endmodule

// File: tb/tb_bram_portb_sched.sv
// Directed bench for bram_portb_sched with a read-first BRAM model (RD_LAT=1) on port B.
module tb_bram_portb_sched;

  logic        clk;
  logic        rst;
  logic        reinit;
  logic        init_done;
  logic        c0_req, c0_we, c0_gnt, c0_rvalid;
  logic [10:0] c0_addr;
  logic [31:0] c0_wdata;
  logic        c1_req, c1_we, c1_gnt, c1_rvalid;
  logic [10:0] c1_addr;
  logic [31:0] c1_wdata;
  logic [31:0] rdata;
  logic        portb_en, portb_we;
  logic [10:0] portb_addr;
  logic [31:0] portb_din;
  logic [31:0] portb_dout;

  logic [31:0] mem [0:2047];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          cli;
    bit          we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  bram_portb_sched dut (
    .clk        (clk),
    .rst        (rst),
    .reinit     (reinit),
    .init_done  (init_done),
    .c0_req     (c0_req),
    .c0_we      (c0_we),
    .c0_addr    (c0_addr),
    .c0_wdata   (c0_wdata),
    .c0_gnt     (c0_gnt),
    .c0_rvalid  (c0_rvalid),
    .c1_req     (c1_req),
    .c1_we      (c1_we),
    .c1_addr    (c1_addr),
    .c1_wdata   (c1_wdata),
    .c1_gnt     (c1_gnt),
    .c1_rvalid  (c1_rvalid),
    .rdata      (rdata),
    .portb_en   (portb_en),
    .portb_we   (portb_we),
    .portb_addr (portb_addr),
    .portb_din  (portb_din),
    .portb_dout (portb_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM port B, one cycle read latency
  always @(posedge clk) begin
    if (portb_en) begin
      if (portb_we) mem[portb_addr] <= portb_din;
      portb_dout <= mem[portb_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] rv_word();
    return {c1_rvalid, c0_rvalid, (c0_rvalid || c1_rvalid) ? rdata : 32'h0};
  endfunction

  // Expects a full ascending fill starting at the next write, then init_done one cycle after it
  task automatic fill_check(input string nm);
    int t;
    int bad;
    t   = 0;
    bad = 0;
    @(negedge clk); #1;
    while (!(portb_en && portb_we) && t < 32) begin
      @(negedge clk); #1;
      t++;
    end
    chk({nm, "_start"}, 64'({portb_en, portb_we, portb_addr}), 64'({1'b1, 1'b1, 11'h000}));
    for (int k = 0; k < 2048; k++) begin
      if (!(portb_en && portb_we && portb_addr == 11'(k) && portb_din == 32'(k)) ||
          init_done || c0_rvalid || c1_rvalid || c0_gnt || c1_gnt)
        bad++;
      @(negedge clk); #1;
    end
    chk({nm, "_bad_cycles"}, 64'(bad), 64'(0));
    chk({nm, "_init_done"}, 64'({init_done, portb_en}), 64'({1'b1, 1'b0}));
  endtask

  initial begin
    int  exp_a;
    bit  hit;
    int  bad;
    logic [1:0]  exp_g;
    logic [33:0] exp_rv;

    vecs[0] = '{1'b1, 1'b1, 11'h005, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 11'h005, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 11'h7FF, 32'h0,        32'h000007FF};
    vecs[3] = '{1'b0, 1'b0, 11'h000, 32'h0,        32'h00000000};
    vecs[4] = '{1'b0, 1'b1, 11'h7FF, 32'h12345678, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 11'h7FF, 32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 11'h005, 32'h0,        32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b1, 11'h000, 32'hA5A5A5A5, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 11'h000, 32'h0,        32'hA5A5A5A5};

    rst = 1'b1; reinit = 1'b0;
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;

    // Outputs while rst is high
    @(negedge clk); #1;
    chk("rst_ctl", 64'({init_done, portb_en, portb_we, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid}), 64'(0));
    chk("rst_data", 64'({portb_addr, portb_din}), 64'(0));
    @(negedge clk);
    rst = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
    fill_check("fill0");

    // Simultaneous reads: c0 first after reset, then c1
    @(negedge clk);
    c0_req = 1'b1; c0_addr = 11'h010; c1_req = 1'b1; c1_addr = 11'h020; #1;
    chk("a_gnt_c0", 64'({c1_gnt, c0_gnt}), 64'(2'b01));
    @(negedge clk); c0_req = 1'b0; #1;
    chk("a_gnt_c1", 64'({c1_gnt, c0_gnt}), 64'(2'b10));
    chk("a_portb_rd", 64'({portb_en, portb_we, portb_addr}), 64'({1'b1, 1'b0, 11'h010}));
    @(negedge clk); c1_req = 1'b0; #1;
    chk("a_rv_c0", 64'(rv_word()), 64'({1'b0, 1'b1, 32'h10}));
    @(negedge clk); #1;
    chk("a_rv_c1", 64'(rv_word()), 64'({1'b1, 1'b0, 32'h20}));
    @(negedge clk); #1;
    chk("a_idle", 64'({c1_rvalid, c0_rvalid, portb_en}), 64'(0));

    // Continuous contention: alternating grants and in-order read returns
    c0_addr = 11'h030; c1_addr = 11'h031;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      c0_req = (i < 8); c1_req = (i < 8); #1;
      exp_g  = (i < 8) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rv = '0;
      if (i >= 2 && i - 2 < 8)
        exp_rv = ((i - 2) % 2 == 0) ? {1'b0, 1'b1, 32'h30} : {1'b1, 1'b0, 32'h31};
      chk($sformatf("b_gnt_%0d", i), 64'({c1_gnt, c0_gnt}), 64'(exp_g));
      chk($sformatf("b_rv_%0d", i), 64'(rv_word()), 64'(exp_rv));
    end
    c0_req = 1'b0; c1_req = 1'b0;

    // Single-client vector table
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      if (vecs[v].cli) begin
        c1_req = 1'b1; c1_we = vecs[v].we; c1_addr = vecs[v].addr; c1_wdata = vecs[v].wdata;
      end else begin
        c0_req = 1'b1; c0_we = vecs[v].we; c0_addr = vecs[v].addr; c0_wdata = vecs[v].wdata;
      end
      #1;
      chk($sformatf("v%0d_gnt", v), 64'({c1_gnt, c0_gnt}), 64'(vecs[v].cli ? 2'b10 : 2'b01));
      @(negedge clk);
      c0_req = 1'b0; c1_req = 1'b0; c0_we = 1'b0; c1_we = 1'b0; #1;
      chk($sformatf("v%0d_portb", v),
          64'({portb_en, portb_we, portb_addr, vecs[v].we ? portb_din : 32'h0}),
          64'({1'b1, vecs[v].we, vecs[v].addr, vecs[v].we ? vecs[v].wdata : 32'h0}));
      @(negedge clk); #1;
      exp_rv = vecs[v].we ? 34'h0 :
               (vecs[v].cli ? {1'b1, 1'b0, vecs[v].exp_rdata} : {1'b0, 1'b1, vecs[v].exp_rdata});
      chk($sformatf("v%0d_rv", v), 64'(rv_word()), 64'(exp_rv));
    end

    // reinit with two reads in flight
    @(negedge clk);
    c0_req = 1'b1; c0_addr = 11'h040; #1;
    chk("c_gnt0", 64'({c1_gnt, c0_gnt}), 64'(2'b01));
    @(negedge clk);
    c0_req = 1'b0; c1_req = 1'b1; c1_addr = 11'h041; #1;
    chk("c_gnt1", 64'({c1_gnt, c0_gnt}), 64'(2'b10));
    @(negedge clk);
    c1_req = 1'b0; c0_req = 1'b1; c0_addr = 11'h042; reinit = 1'b1; #1;
    chk("c_blocked", 64'({c1_gnt, c0_gnt, init_done}), 64'(3'b001));
    chk("c_rv0", 64'(rv_word()), 64'({1'b0, 1'b1, 32'h40}));
    @(negedge clk); reinit = 1'b0; #1;
    chk("c_rv1", 64'(rv_word()), 64'({1'b1, 1'b0, 32'h41}));
    chk("c_done_low", 64'({init_done, c0_gnt, c1_gnt}), 64'(0));
    @(negedge clk); #1;
    chk("c_drained", 64'({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, portb_en, init_done}), 64'(0));
    c0_req = 1'b0;
    fill_check("c_fill");

    // Refill, ignore a reinit mid-fill, then rst at fill address 0x400
    @(negedge clk); reinit = 1'b1;
    @(negedge clk); reinit = 1'b0;
    exp_a = 0; hit = 1'b0; bad = 0;
    for (int t = 0; t < 2100 && !hit; t++) begin
      @(negedge clk);
      reinit = (exp_a == 'h101);
      if (exp_a == 'h400) begin
        hit = 1'b1; reinit = 1'b0; rst = 1'b1; c0_req = 1'b1; c0_addr = 11'h000; #1;
        chk("d_rst_ctl", 64'({init_done, portb_en, portb_we, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid}), 64'(0));
        chk("d_rst_data", 64'({portb_addr, rdata}), 64'(0));
        chk("d_rst_din", 64'(portb_din), 64'(0));
      end else begin
        #1;
        if (portb_en && portb_we) begin
          if (portb_addr != 11'(exp_a) || portb_din != 32'(exp_a) || init_done) bad++;
          exp_a++;
        end
      end
    end
    reinit = 1'b0;
    chk("d_reached_400", 64'(hit), 64'(1));
    chk("d_partial_fill", 64'(bad), 64'(0));
    @(negedge clk); rst = 1'b0; c0_req = 1'b0;
    fill_check("d_fill");

    // rst with a read in flight: no rvalid, pointer returns to c0
    @(negedge clk);
    c0_req = 1'b1; c0_addr = 11'h010; c1_req = 1'b1; c1_addr = 11'h020; #1;
    chk("e_gnt", 64'({c1_gnt, c0_gnt}), 64'(2'b01));
    @(negedge clk); c0_req = 1'b0; c1_req = 1'b0; rst = 1'b1; #1;
    chk("e_rst", 64'({c0_rvalid, c1_rvalid, portb_en, init_done}), 64'(0));
    @(negedge clk); rst = 1'b0; #1;
    chk("e_no_rvalid", 64'({c0_rvalid, c1_rvalid}), 64'(0));
    fill_check("e_fill");
    @(negedge clk);
    c0_req = 1'b1; c1_req = 1'b1; #1;
    chk("f_ptr_reset", 64'({c1_gnt, c0_gnt}), 64'(2'b01));
    @(negedge clk); c0_req = 1'b0; #1;
    chk("f_second", 64'({c1_gnt, c0_gnt}), 64'(2'b10));
    @(negedge clk); c1_req = 1'b0; #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_portb_sched.md
BRAM_PORTB_SCHED -- requirements
Module: bram_portb_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, BRAM word-address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 32, BRAM word width.
REQ-003 SHALL have parameter RD_LAT, default 1, BRAM port-B read latency in cycles, legal 1..3.
REQ-004 SHALL have parameter INIT_BASE, default 0, DATA_W-bit value added to the address to form the init pattern.
REQ-005 SHALL have port clk  in  1  clock shared by BRAM port B and all clients.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port reinit  in  1  single-cycle request to re-run the fill.
REQ-008 SHALL have port init_done  out  1  high while the BRAM holds a complete pattern and clients are served.
REQ-009 SHALL have ports cN_req / cN_we  in  1 / 1  (N=0,1), meaning access request / write-not-read.
REQ-010 SHALL have ports cN_addr / cN_wdata  in  ADDR_W / DATA_W  (N=0,1), meaning word address / write data.
REQ-011 SHALL have ports cN_gnt / cN_rvalid  out  1 / 1  (N=0,1), meaning request accepted / read data valid.
REQ-012 SHALL have port rdata  out  DATA_W  read data, qualified by cN_rvalid.
REQ-013 SHALL have ports portb_en, portb_we, portb_addr, portb_din  out  1, 1, ADDR_W, DATA_W  driving BRAM port B.
REQ-014 SHALL have port portb_dout  in  DATA_W  BRAM port-B read data.

Function
REQ-015 SHALL implement states INIT, RUN, DRAIN; reset enters INIT.
REQ-016 INIT SHALL write address k with INIT_BASE+k (mod 2^DATA_W), one word per cycle, k = 0..2^ADDR_W-1 ascending, portb_en=portb_we=1.
REQ-017 After the write to the last address, INIT SHALL move to RUN; init_done SHALL rise the following cycle.
REQ-018 In RUN, cN_gnt SHALL be combinational from cN_req in the same cycle, at most one grant per cycle.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the client not granted most recently wins; after reset, c0 has priority.
REQ-020 A client SHALL hold req, we, addr, wdata stable until gnt; gnt on a cycle without req is forbidden.
REQ-021 The granted access SHALL appear registered on portb_* exactly one cycle after gnt; portb_en=0 on cycles following no grant.
REQ-022 For a granted read, cN_rvalid SHALL pulse exactly 1+RD_LAT cycles after gnt with rdata=portb_dout of that cycle; writes produce no rvalid.
REQ-023 Reads SHALL complete in grant order; back-to-back grants every cycle SHALL be sustained.
REQ-024 reinit in RUN SHALL block grants from that cycle, clear init_done the next cycle, and enter DRAIN.
REQ-025 DRAIN SHALL deliver all outstanding rvalids, then enter INIT restarting at address 0.
REQ-026 reinit in INIT or DRAIN SHALL be ignored; cN_gnt SHALL be 0 in INIT and DRAIN.

Reset
REQ-027 rst SHALL force state INIT, fill address 0, round-robin pointer to c0, and clear the read-valid pipeline.
REQ-028 During the cycle rst is high, all outputs SHALL be 0, including init_done, grants, rvalids, rdata, and portb_*.
REQ-029 rst mid-fill or mid-read SHALL abandon the operation, with no rvalid emitted for in-flight reads.

Structure
REQ-030 State encoding and default widths SHALL live in shared package bram_pkg.
REQ-031 Arbitration SHALL be one sub-module, rr_arb2: 2-way round-robin, request in, one-hot grant out, pointer updated on grant.

Verification
REQ-032 Reset then idle -> portb_we high 2048 consecutive cycles, addr 0..0x7FF, din=addr; init_done high at cycle 2049.
REQ-033 c0 reads addr 0x010 while c1 reads 0x020 in the same cycle -> c0_gnt, then c1_gnt next cycle; c0_rvalid with rdata 0x10 at gnt+2 (RD_LAT=1), then c1_rvalid with 0x20.
REQ-034 Both clients request continuously for 8 cycles -> grants alternate c0,c1,c0,... with one grant per cycle.
REQ-035 c1 writes 0xDEADBEEF to 0x005, then reads 0x005 -> rdata 0xDEADBEEF.
REQ-036 reinit pulsed with 2 reads in flight -> both rvalids delivered, no new grants, then a full fill restarting at address 0.
REQ-037 rst asserted at fill address 0x400 -> fill restarts at 0, init_done stays 0 until a complete fill.
